// File: rtl/nibble_demux.sv
// Receive side of the shared nibble bus: rebuilds A/B pairs from a select-tagged
// stream, hands them downstream via valid/ready and counts out-of-order beats.
module nibble_demux #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  state_t state_q, state_d;
  logic   xfer;
  logic   a_load;
  logic   b_load;
  logic   bad_beat;

  // Handshake outputs are decoded from the registered state only, so there is
  // no combinational path from pair_ready back to in_ready.
  assign in_ready   = (state_q != HOLD);
  assign pair_valid = (state_q == HOLD);
  assign xfer       = in_valid & in_ready;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_load   = 1'b0;
    b_load   = 1'b0;
    bad_beat = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (xfer) begin
          if (!in_sel) begin
            a_load  = 1'b1;
            state_d = WAIT_B;
          end else begin
            bad_beat = 1'b1;
          end
        end
      end
      WAIT_B: begin
        if (xfer) begin
          if (in_sel) begin
            b_load  = 1'b1;
            state_d = HOLD;
          end else begin
            // A newer A replaces the pending one; still flagged as misordered.
            a_load   = 1'b1;
            bad_beat = 1'b1;
          end
        end
      end
      HOLD: begin
        if (pair_ready) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_A;
      a_out   <= '0;
      b_out   <= '0;
      seq_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      seq_err <= bad_beat;
      if (a_load) a_out <= in_data;
      if (b_load) b_out <= in_data;
      // Clear has priority over a coincident increment; count sticks at max.
      if (err_clr)
        err_cnt <= '0;
      else if (bad_beat && (err_cnt != ERR_MAX))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
